// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the multiply/divide unit: FSM states, default
// operand width and the iteration-counter width helper.
package mult_div_unit_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MULT = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Counter must hold 0..WIDTH-1 with one spare bit of headroom.
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/mult_div_unit_signed_div_core.sv
// Signed restoring divider datapath: magnitude conversion on load, one
// shift-subtract step per enabled cycle, and sign fix-up of the results.
// quotient/remainder reflect the state *after* the current step so the
// parent can capture them on the same edge that completes the last step.
module signed_div_core #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;

    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   diff;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? ('0 - v) : v;
    endfunction

    // Operand capture on load, one restoring iteration per step.
    always_comb begin
        quo_d     = quo_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        rem_shift = {rem_q, quo_q[WIDTH-1]};
        diff      = rem_shift - {1'b0, dvs_q};
        if (load) begin
            quo_d     = magnitude(dividend);
            rem_d     = '0;
            dvs_d     = magnitude(divisor);
            neg_quo_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_rem_d = dividend[WIDTH-1];
        end else if (step) begin
            if (diff[WIDTH]) begin
                rem_d = rem_shift[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], 1'b0};
            end else begin
                rem_d = diff[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], 1'b1};
            end
        end
    end

    // Sign fix-up: quotient truncates toward zero, remainder follows dividend.
    always_comb begin
        quotient  = neg_quo_q ? ('0 - quo_d) : quo_d;
        remainder = neg_rem_q ? ('0 - rem_d) : rem_d;
    end

    // Divider state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dvs_q     <= dvs_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Multicycle signed multiply (radix-2 Booth) / divide (restoring) unit
// feeding the HI/LO registers, sequenced by a start/done handshake.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mult_start,
    input  logic             div_start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int unsigned CW = cnt_width(WIDTH);

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    // {P_hi, P_lo, q_-1}
    logic [2*WIDTH:0]   prod_q, prod_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               dz_q, dz_d;

    logic [WIDTH:0]     ph_ext;
    logic [WIDTH:0]     mc_ext;
    logic [WIDTH:0]     booth_sum;
    logic [2*WIDTH:0]   booth_next;

    logic               div_load;
    logic               div_step;
    logic [WIDTH-1:0]   div_quot;
    logic [WIDTH-1:0]   div_rem;
    logic               last_iter;

    signed_div_core #(.WIDTH(WIDTH)) u_div (
        .clk       (clk),
        .reset     (reset),
        .load      (div_load),
        .step      (div_step),
        .dividend  (op_a),
        .divisor   (op_b),
        .quotient  (div_quot),
        .remainder (div_rem)
    );

    // One Booth step: add/subtract at WIDTH+1 bits, then arithmetic shift.
    // The extra sum bit becomes the new P_hi sign after the shift.
    always_comb begin
        ph_ext = {prod_q[2*WIDTH], prod_q[2*WIDTH:WIDTH+1]};
        mc_ext = {mcand_q[WIDTH-1], mcand_q};
        unique case (prod_q[1:0])
            2'b01:   booth_sum = ph_ext + mc_ext;
            2'b10:   booth_sum = ph_ext - mc_ext;
            default: booth_sum = ph_ext;
        endcase
        booth_next = {booth_sum[WIDTH:1], booth_sum[0], prod_q[WIDTH:2], prod_q[1]};
    end

    // FSM next state, datapath updates and result capture on entry to DONE.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mcand_d   = mcand_q;
        prod_d    = prod_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        dz_d      = 1'b0;
        div_load  = 1'b0;
        div_step  = 1'b0;
        last_iter = (cnt_q == CW'(WIDTH - 1));
        unique case (state_q)
            ST_IDLE: begin
                if (mult_start) begin
                    mcand_d = op_a;
                    prod_d  = {{WIDTH{1'b0}}, op_b, 1'b0};
                    cnt_d   = '0;
                    state_d = ST_MULT;
                end else if (div_start) begin
                    if (op_b == '0) begin
                        dz_d    = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        div_load = 1'b1;
                        cnt_d    = '0;
                        state_d  = ST_DIV;
                    end
                end
            end
            ST_MULT: begin
                prod_d = booth_next;
                cnt_d  = cnt_q + CW'(1);
                if (last_iter) begin
                    hi_d    = booth_next[2*WIDTH:WIDTH+1];
                    lo_d    = booth_next[WIDTH:1];
                    state_d = ST_DONE;
                end
            end
            ST_DIV: begin
                div_step = 1'b1;
                cnt_d    = cnt_q + CW'(1);
                if (last_iter) begin
                    hi_d    = div_rem;
                    lo_d    = div_quot;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Status outputs decoded from the state register.
    always_comb begin
        busy     = (state_q == ST_MULT) || (state_q == ST_DIV);
        done     = (state_q == ST_DONE);
        div_zero = (state_q == ST_DONE) && dz_q;
        hi_out   = hi_q;
        lo_out   = lo_q;
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mcand_q <= '0;
            prod_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mcand_q <= mcand_d;
            prod_q  <= prod_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dz_q    <= dz_d;
        end
    end

endmodule
